neuron_seq: RTL and testbench
=============================

Name: neuron_seq

Overview:
- Upstream sequencer for a single `neuron` MAC.
- On a start pulse it reads LEN weight/data pairs from two synchronous-read memories (weight ROM, activation buffer) and drives the neuron's weight/data/en/clear.
- Once the last product has been accumulated, it captures the neuron's 18-bit FloPoCo accum into a result register. The result is offered downstream with a valid/ready handshake.
- One dot product is in flight at a time.

Parameters:
- BITWIDTH, 16, FP payload width; bus width is BITWIDTH+2 (FloPoCo exception bits included).
- BW, BITWIDTH+1, MSB index of FP buses.
- MAX_LEN, 256, maximum vector length.
- ADDR_W, $clog2(MAX_LEN), memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  one-cycle request; accepted only in IDLE.
- len  in  ADDR_W+1  vector length 0..MAX_LEN; sampled with an accepted start.
- w_base  in  ADDR_W  weight memory base address; sampled with start.
- d_base  in  ADDR_W  data memory base address; sampled with start.
- mem_rd_en  out  1  read strobe to both memories.
- w_addr  out  ADDR_W  weight read address.
- d_addr  out  ADDR_W  data read address.
- w_rdata  in  [BW:0]  weight memory output, valid 1 cycle after mem_rd_en.
- d_rdata  in  [BW:0]  data memory output, valid 1 cycle after mem_rd_en.
- n_weight  out  [BW:0]  to neuron weight; combinational pass of w_rdata.
- n_data  out  [BW:0]  to neuron data; combinational pass of d_rdata.
- n_en  out  1  to neuron en.
- n_clear  out  1  to neuron clear.
- n_accum  in  [BW:0]  from neuron accum.
- busy  out  1  high in every state except IDLE.
- res  out  [BW:0]  captured dot-product result.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.

Behaviour:
- Reset (rst=0, asynchronous): state returns to IDLE. All outputs are 0: mem_rd_en, addresses, n_en, n_clear, busy, res, res_valid. Internal counter and the en pipeline register also clear. Reset asserted mid-operation abandons the job; no result is produced.
- FSM states: IDLE, CLEAR, RUN, DRAIN, OUT.
  - IDLE: start=1 latches len, w_base, d_base, sets idx=0, next state CLEAR. start while busy is ignored, not queued.
  - CLEAR (1 cycle): n_clear=1, n_en=0. Next state is RUN if len>0, else DRAIN.
  - RUN (len cycles): mem_rd_en=1, w_addr=w_base+idx, d_addr=d_base+idx (wrap mod 2^ADDR_W), idx++. Leaves for DRAIN after the cycle in which idx==len-1.
  - n_en is mem_rd_en registered one cycle, so en asserts exactly when the memory data appears. n_en is high for exactly len cycles.
  - DRAIN: stays until the registered en is 0; the neuron accum now holds the final sum. In that cycle res<=n_accum and the state moves to OUT.
  - OUT: res_valid=1, res held stable. res_valid&res_ready returns the FSM to IDLE next cycle. A start in the same cycle as the handshake is ignored (IDLE is required).
- Timing for an accepted start at edge T0: CLEAR is cycle 1, RUN is cycles 2..len+1, n_en is high in cycles 3..len+2, DRAIN is cycle len+3, res_valid rises in cycle len+4.
- len=0: res_valid rises in cycle 3 with res=18'h00000 (cleared accum).
- n_clear and n_en are never high in the same cycle. n_en is 0 in IDLE, CLEAR and OUT.
- No arithmetic is performed here; FP values pass through unchanged.

Test Plan:
- Reset with rst=0 mid-RUN (len=8, after 3 reads) → all outputs 0 immediately (asynchronous); after release, state is IDLE and res_valid never asserts for the abandoned job.
- Basic dot product with the neuron attached: weights {13C00 (1.0), 14000 (2.0), 14200 (3.0)}, data {14000, 13C00, 13C00}, len=3, res_ready=1 → n_en high exactly 3 cycles; res=18'h14700 (7.0) with res_valid in cycle 7 after start.
- len=0 → n_clear for one cycle, no mem_rd_en; res=0 with res_valid in cycle 3.
- Backpressure: res_ready=0 for 10 cycles → res and res_valid held stable, busy=1; a start pulsed during that window is ignored; res_ready=1 → IDLE next cycle.
- Back-to-back jobs: second job (len=2, values 1.0·1.0 twice) right after the first handshake → n_clear precedes it, so res=18'h14000 (2.0) with no carry-over from the previous sum.
- Address wrap: MAX_LEN=256, w_base=254, len=4 → w_addr sequence 254, 255, 0, 1; len=MAX_LEN → exactly 256 reads, each address issued once.

Source files
------------

// File: rtl/neuron_seq.sv
// Sequencer feeding a single FloPoCo MAC: streams LEN weight/data pairs from two
// synchronous-read memories into the neuron, then hands the captured sum downstream.
module neuron_seq #(
    parameter int BITWIDTH = 16,
    parameter int BW       = BITWIDTH + 1,
    parameter int MAX_LEN  = 256,
    parameter int ADDR_W   = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] d_base,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] d_addr,
    input  logic [BW:0]       w_rdata,
    input  logic [BW:0]       d_rdata,
    output logic [BW:0]       n_weight,
    output logic [BW:0]       n_data,
    output logic              n_en,
    output logic              n_clear,
    input  logic [BW:0]       n_accum,
    output logic              busy,
    output logic [BW:0]       res,
    output logic              res_valid,
    input  logic              res_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic [ADDR_W-1:0] d_base_q, d_base_d;
    logic              en_q, en_d;
    logic [BW:0]       res_q, res_d;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        w_base_d  = w_base_q;
        d_base_d  = d_base_q;
        res_d     = res_q;
        mem_rd_en = 1'b0;
        n_clear   = 1'b0;
        w_addr    = '0;
        d_addr    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = len;
                    w_base_d = w_base;
                    d_base_d = d_base;
                    idx_d    = '0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                n_clear = 1'b1;
                state_d = (len_q != '0) ? S_RUN : S_DRAIN;
            end
            S_RUN: begin
                // Address sums are ADDR_W wide so they wrap around the memory.
                mem_rd_en = 1'b1;
                w_addr    = w_base_q + idx_q[ADDR_W-1:0];
                d_addr    = d_base_q + idx_q[ADDR_W-1:0];
                idx_d     = idx_q + (ADDR_W+1)'(1);
                if (idx_q == len_q - (ADDR_W+1)'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Once the en pipeline is empty the last product is in the accumulator.
                if (!en_q) begin
                    res_d   = n_accum;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // en trails the read strobe by the memory latency, so it lines up with rdata.
        en_d = mem_rd_en;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            w_base_q <= '0;
            d_base_q <= '0;
            en_q     <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            w_base_q <= w_base_d;
            d_base_q <= d_base_d;
            en_q     <= en_d;
            res_q    <= res_d;
        end
    end

    assign n_weight  = w_rdata;
    assign n_data    = d_rdata;
    assign n_en      = en_q;
    assign busy      = (state_q != S_IDLE);
    assign res       = res_q;
    assign res_valid = (state_q == S_OUT);

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: behavioural memories, a real-valued stand-in for the neuron,
// and a reference that computes each dot product directly from the memory arrays.
module tb_neuron_seq;

    localparam int AW = 8;
    localparam int ML = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [AW:0] len = '0;
    logic [AW-1:0] w_base = '0;
    logic [AW-1:0] d_base = '0;
    logic        mem_rd_en;
    logic [AW-1:0] w_addr, d_addr;
    logic [17:0] w_rdata, d_rdata;
    logic [17:0] n_weight, n_data, n_accum;
    logic        n_en, n_clear, busy, res_valid;
    logic [17:0] res;
    logic        res_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    neuron_seq dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .w_base(w_base), .d_base(d_base),
        .mem_rd_en(mem_rd_en), .w_addr(w_addr), .d_addr(d_addr),
        .w_rdata(w_rdata), .d_rdata(d_rdata),
        .n_weight(n_weight), .n_data(n_data),
        .n_en(n_en), .n_clear(n_clear), .n_accum(n_accum),
        .busy(busy), .res(res), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // FloPoCo 18-bit: {exc[1:0], sign, exp[4:0] (bias 15), mant[9:0]}; exc 01 = normal.
    function automatic real fp2r(input logic [17:0] f);
        real v;
        int  e;
        if (f[17:16] != 2'b01) return 0.0;
        v = 1.0 + real'(f[9:0]) / 1024.0;
        e = int'(f[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[15] ? -v : v;
    endfunction

    function automatic logic [17:0] r2fp(input real x);
        real a;
        int  e;
        int  m;
        logic s;
        logic [4:0] ev;
        logic [9:0] mv;
        if (x == 0.0) return 18'h0;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        if (e < 1)  return 18'h0;
        if (e > 30) return {2'b10, s, 15'h0};
        m  = $rtoi((a - 1.0) * 1024.0);
        ev = e[4:0];
        mv = m[9:0];
        return {2'b01, s, ev, mv};
    endfunction

    // Synchronous-read memories.
    logic [17:0] wmem [ML];
    logic [17:0] dmem [ML];
    always @(posedge clk) begin
        if (mem_rd_en) begin
            w_rdata <= wmem[w_addr];
            d_rdata <= dmem[d_addr];
        end
    end

    // Stand-in neuron: exact real accumulation, presented in FloPoCo format.
    real acc_r = 0.0;
    always @(posedge clk) begin
        if (n_clear)   acc_r <= 0.0;
        else if (n_en) acc_r <= acc_r + fp2r(n_weight) * fp2r(n_data);
    end
    always_comb n_accum = r2fp(acc_r);

    // Bus monitor.
    logic [AW-1:0] waddr_q[$];
    logic [AW-1:0] daddr_q[$];
    int en_cnt = 0;
    int clr_cnt = 0;
    int overlap = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (mem_rd_en) begin
                waddr_q.push_back(w_addr);
                daddr_q.push_back(d_addr);
            end
            if (n_en)            en_cnt  <= en_cnt + 1;
            if (n_clear)         clr_cnt <= clr_cnt + 1;
            if (n_en && n_clear) overlap <= overlap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model(input int l, input int wb, input int db);
        real acc = 0.0;
        for (int i = 0; i < l; i++)
            acc = acc + fp2r(wmem[(wb + i) % ML]) * fp2r(dmem[(db + i) % ML]);
        return r2fp(acc);
    endfunction

    function automatic logic [17:0] rand_fp();
        logic [4:0] e;
        logic [9:0] m;
        e = 5'($urandom_range(12, 18));
        m = 10'($urandom);
        return {2'b01, 1'($urandom), e, m};
    endfunction

    logic [17:0] last_res;

    // Caller is positioned at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic run_job(input int l, input int wb, input int db, input int hold, input bit poke);
        int q0, en0, clr0, cyc, bad, unstable;
        logic [17:0] exp_res, held;
        q0      = waddr_q.size();
        en0     = en_cnt;
        clr0    = clr_cnt;
        exp_res = model(l, wb, db);
        start = 1'b1; len = l[AW:0]; w_base = wb[AW-1:0]; d_base = db[AW-1:0];
        res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < l + 12) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, (l == 0) ? 3 : l + 4);
        check("res_valid", res_valid, 1);
        check("res", res, exp_res);
        check("busy_out", busy, 1);
        check("en_cycles", en_cnt - en0, l);
        check("clear_cycles", clr_cnt - clr0, 1);
        check("rd_count", waddr_q.size() - q0, l);
        bad = 0;
        for (int i = 0; i < l && q0 + i < waddr_q.size(); i++) begin
            if (waddr_q[q0 + i] != AW'((wb + i) % ML)) bad++;
            if (daddr_q[q0 + i] != AW'((db + i) % ML)) bad++;
        end
        check("addr_seq", bad, 0);
        held = res;
        unstable = 0;
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (res !== held || res_valid !== 1'b1 || busy !== 1'b1) unstable++;
        end
        if (hold > 0) check("hold_stable", unstable, 0);
        res_ready = 1'b1;
        if (poke) start = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        check("idle_after_hs", busy, 0);
        check("valid_drop", res_valid, 0);
        if (poke) begin
            @(negedge clk);
            check("start_not_queued", busy, 0);
        end
        last_res = held;
    endtask

    initial begin
        int seen_valid;

        for (int i = 0; i < ML; i++) begin
            wmem[i] = rand_fp();
            dmem[i] = rand_fp();
        end

        // Reset state.
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_rd", mem_rd_en, 0);
        check("rst_res", res, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic 3-element dot product: 1*2 + 2*1 + 3*1 = 7.0.
        wmem[0] = 18'h13C00; wmem[1] = 18'h14000; wmem[2] = 18'h14200;
        dmem[0] = 18'h14000; dmem[1] = 18'h13C00; dmem[2] = 18'h13C00;
        run_job(3, 0, 0, 0, 1'b0);
        check("basic_7p0", last_res, 18'h14700);

        // Back-to-back: 1.0*1.0 twice must not carry the previous 7.0.
        wmem[10] = 18'h13C00; wmem[11] = 18'h13C00;
        dmem[20] = 18'h13C00; dmem[21] = 18'h13C00;
        run_job(2, 10, 20, 0, 1'b0);
        check("b2b_2p0", last_res, 18'h14000);

        // Empty vector.
        run_job(0, 5, 6, 0, 1'b0);
        check("len0_zero", last_res, 18'h0);

        // Backpressure with starts poked into the hold window and handshake cycle.
        run_job(5, 100, 200, 10, 1'b1);

        // Address wrap and full-length vector.
        run_job(4, 254, 253, 0, 1'b0);
        run_job(ML, 17, 250, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 10; j++)
            run_job($urandom_range(0, 24), $urandom_range(0, ML - 1),
                    $urandom_range(0, ML - 1), $urandom_range(0, 3), 1'($urandom));

        // Asynchronous reset mid-RUN after 3 reads abandons the job.
        start = 1'b1; len = 9'd8; w_base = 8'd0; d_base = 8'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_rd", mem_rd_en, 0);
        check("arst_waddr", w_addr, 0);
        check("arst_daddr", d_addr, 0);
        check("arst_en", n_en, 0);
        check("arst_clear", n_clear, 0);
        check("arst_busy", busy, 0);
        check("arst_res", res, 0);
        check("arst_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid || busy) seen_valid++;
        end
        check("abandoned_no_result", seen_valid, 0);

        check("clear_en_exclusive", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
